// File: rtl/isp_pkg.sv
// Shared ISP stream definitions: channel codes, denoise mode codes and per-beat metadata.
package isp_pkg;
  localparam int COLOR_DEPTH = 8;

  typedef enum logic [2:0] {RED = 3'd0, GREEN = 3'd1, BLUE = 3'd2, VOID = 3'd3} colour_e;
  typedef enum logic [1:0] {DN_GAUSS = 2'd0, DN_PASS = 2'd1, DN_CLAMP = 2'd2} dn_mode_e;

  typedef struct packed {
    logic [2:0] color;
    logic       last;
  } dn_meta_t;
endpackage

// File: rtl/denoise_kernel3x3.sv
// Combinational 3x3 filter: Gaussian 1-2-1, centre passthrough, or clamp to neighbour range.
module denoise_kernel3x3 #(
  parameter int CD = isp_pkg::COLOR_DEPTH
) (
  input  logic [8:0][CD-1:0] win,
  input  logic [1:0]         mode,
  output logic [CD-1:0]      pix
);
  import isp_pkg::*;

  logic [CD+3:0] sum, rnd;
  logic [CD-1:0] mn, mx;

  always_comb begin
    sum = (CD+4)'(win[0]) + (CD+4)'(win[2]) + (CD+4)'(win[6]) + (CD+4)'(win[8])
        + (((CD+4)'(win[1]) + (CD+4)'(win[3]) + (CD+4)'(win[5]) + (CD+4)'(win[7])) << 1)
        + ((CD+4)'(win[4]) << 2);
    // Max sum is 16*max, so +8 still fits in CD+4 bits.
    rnd = sum + (CD+4)'(8);
  end

  always_comb begin
    mn = win[0];
    mx = win[0];
    for (int i = 1; i < 9; i++) begin
      if (i != 4) begin
        if (win[i] < mn) mn = win[i];
        if (win[i] > mx) mx = win[i];
      end
    end
  end

  always_comb begin
    pix = win[4];
    case (dn_mode_e'(mode))
      DN_GAUSS: pix = rnd[CD+3:4];
      DN_CLAMP: pix = (win[4] < mn) ? mn : ((win[4] > mx) ? mx : win[4]);
      default:  pix = win[4];
    endcase
  end
endmodule

// File: rtl/denoise_window3x3.sv
// Interleaved-RGB 3x3 denoiser: per-channel line buffers and windows, one shared kernel,
// interior pixels only, output two cycles after the accepting edge.
module denoise_window3x3 #(
  parameter int COLOR_DEPTH = isp_pkg::COLOR_DEPTH,
  parameter int IMG_WIDTH   = 12,
  parameter int IMG_HEIGHT  = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             mode,
  input  logic [COLOR_DEPTH-1:0] pixel_in,
  input  logic                   valid_in,
  input  logic [2:0]             color_in,
  input  logic                   last_in,
  output logic [COLOR_DEPTH-1:0] pixel_out,
  output logic                   valid_out,
  output logic [2:0]             color_out,
  output logic                   last_out,
  output logic                   err
);
  import isp_pkg::*;

  localparam int CW     = $clog2(IMG_WIDTH);
  localparam int RW     = $clog2(IMG_HEIGHT);
  localparam int STAGES = 2;

  logic [CW-1:0] col, col_n;
  logic [RW-1:0] row, row_n;
  logic [2:0]    exp_c, exp_n;
  logic [1:0]    mode_q, mode_n;
  logic          err_n;
  logic          acc, mism, at_final, gen, fin_beat;
  logic [1:0]    ch, ch_q;

  logic [COLOR_DEPTH-1:0] lb_a [3][IMG_WIDTH];
  logic [COLOR_DEPTH-1:0] lb_b [3][IMG_WIDTH];
  logic [COLOR_DEPTH-1:0] win  [3][9];

  logic [STAGES:0]                vld_pipe;
  dn_meta_t                       meta1, meta2;
  logic [8:0][COLOR_DEPTH-1:0]    kwin;
  logic [COLOR_DEPTH-1:0]         kpix, pix2;

  assign ch       = color_in[1:0];
  assign acc      = valid_in && (color_in != VOID) && (color_in == exp_c);
  assign mism     = valid_in && (color_in != VOID) && (color_in != exp_c);
  assign at_final = (col == CW'(IMG_WIDTH-1)) && (row == RW'(IMG_HEIGHT-1));
  assign gen      = acc && (col >= CW'(2)) && (row >= RW'(2));
  assign fin_beat = acc && (color_in == BLUE) && at_final;

  always_comb begin
    col_n  = col;
    row_n  = row;
    exp_n  = exp_c;
    mode_n = mode_q;
    err_n  = err || mism;
    if (acc) begin
      if ((col == '0) && (row == '0) && (exp_c == RED)) mode_n = mode;
      if (last_in) begin
        // Any last_in restarts the frame; only the final BLUE beat is legal.
        if (!((color_in == BLUE) && at_final)) err_n = 1'b1;
        col_n = '0;
        row_n = '0;
        exp_n = RED;
      end else begin
        case (exp_c)
          RED:   exp_n = GREEN;
          GREEN: exp_n = BLUE;
          default: begin
            exp_n = RED;
            if (at_final) begin
              err_n = 1'b1;
              col_n = '0;
              row_n = '0;
            end else if (col == CW'(IMG_WIDTH-1)) begin
              col_n = '0;
              row_n = row + 1'b1;
            end else begin
              col_n = col + 1'b1;
            end
          end
        endcase
      end
    end
  end

  // Window row 0 is the oldest line (row-2); column 2 is the newest sample.
  always_ff @(posedge clk) begin
    if (acc) begin
      for (int r = 0; r < 3; r++) begin
        win[ch][r*3]   <= win[ch][r*3+1];
        win[ch][r*3+1] <= win[ch][r*3+2];
      end
      win[ch][2]    <= lb_b[ch][col];
      win[ch][5]    <= lb_a[ch][col];
      win[ch][8]    <= pixel_in;
      lb_b[ch][col] <= lb_a[ch][col];
      lb_a[ch][col] <= pixel_in;
    end
  end

  always_comb begin
    for (int i = 0; i < 9; i++) kwin[i] = win[ch_q][i];
  end

  denoise_kernel3x3 #(.CD(COLOR_DEPTH)) u_kernel (
    .win  (kwin),
    .mode (mode_q),
    .pix  (kpix)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col       <= '0;
      row       <= '0;
      exp_c     <= RED;
      mode_q    <= DN_GAUSS;
      err       <= 1'b0;
      vld_pipe  <= '0;
      ch_q      <= '0;
      meta1     <= '{color: VOID, last: 1'b0};
      meta2     <= '{color: VOID, last: 1'b0};
      pix2      <= '0;
      pixel_out <= '0;
      color_out <= VOID;
      last_out  <= 1'b0;
    end else begin
      col      <= col_n;
      row      <= row_n;
      exp_c    <= exp_n;
      mode_q   <= mode_n;
      err      <= err_n;
      vld_pipe <= {vld_pipe[STAGES-1:0], gen};
      if (acc) ch_q <= ch;
      meta1.color <= gen ? color_in : VOID;
      meta1.last  <= fin_beat;
      meta2       <= meta1;
      pix2        <= kpix;
      pixel_out   <= pix2;
      color_out   <= meta2.color;
      last_out    <= meta2.last;
    end
  end

  assign valid_out = vld_pipe[STAGES];
endmodule

// File: tb/tb_denoise_window3x3.sv
// Scoreboard bench: expected interior samples are computed from a frame image and queued as beats are driven.
module tb_denoise_window3x3;
  localparam int CD = 8, W = 12, H = 6, NPIX = W*H;

  logic          clk = 1'b0, rst = 1'b1;
  logic [1:0]    mode = 2'd0;
  logic [CD-1:0] pixel_in = '0;
  logic          valid_in = 1'b0;
  logic [2:0]    color_in = 3'd3;
  logic          last_in = 1'b0;
  logic [CD-1:0] pixel_out;
  logic          valid_out, last_out, err;
  logic [2:0]    color_out;

  denoise_window3x3 #(.COLOR_DEPTH(CD), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .rst(rst), .mode(mode), .pixel_in(pixel_in), .valid_in(valid_in),
    .color_in(color_in), .last_in(last_in), .pixel_out(pixel_out), .valid_out(valid_out),
    .color_out(color_out), .last_out(last_out), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {int ch; int x; int y; int pix; bit last; int cyc;} exp_t;
  exp_t sbq[$];
  exp_t mon_e;
  int img [3][H][W];
  int got [3][H][W];
  int errors = 0, checks = 0, cyc = 0, out_cnt = 0, last_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int model(int ch, int cx, int cy, int md);
    int s = 0, mn = 1 << 30, mx = -1, c, v;
    c = img[ch][cy][cx];
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++) begin
        v = img[ch][cy+dy][cx+dx];
        s += v * ((dx == 0) ? 2 : 1) * ((dy == 0) ? 2 : 1);
        if (!(dx == 0 && dy == 0)) begin
          if (v < mn) mn = v;
          if (v > mx) mx = v;
        end
      end
    case (md)
      0: return (s + 8) >> 4;
      2: return (c < mn) ? mn : ((c > mx) ? mx : c);
      default: return c;
    endcase
  endfunction

  // Output side of the scoreboard: every valid_out beat is popped and compared.
  always begin
    @(posedge clk); #1;
    if (valid_out) begin
      out_cnt++;
      if (last_out) last_cnt++;
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out got pixel=%0d color=%0d, want no output", pixel_out, color_out);
      end else begin
        mon_e = sbq.pop_front();
        got[mon_e.ch][mon_e.y][mon_e.x] = pixel_out;
        checks += 3;
        if (pixel_out !== CD'(mon_e.pix)) begin errors++;
          $display("FAIL pixel ch%0d (%0d,%0d) got=%0d want=%0d", mon_e.ch, mon_e.x, mon_e.y, pixel_out, mon_e.pix); end
        if (color_out !== 3'(mon_e.ch)) begin errors++;
          $display("FAIL color (%0d,%0d) got=%0d want=%0d", mon_e.x, mon_e.y, color_out, mon_e.ch); end
        if (last_out !== mon_e.last) begin errors++;
          $display("FAIL last ch%0d (%0d,%0d) got=%0b want=%0b", mon_e.ch, mon_e.x, mon_e.y, last_out, mon_e.last); end
        if (cyc != mon_e.cyc) begin errors++;
          $display("FAIL latency ch%0d (%0d,%0d) got_cycle=%0d want_cycle=%0d", mon_e.ch, mon_e.x, mon_e.y, cyc, mon_e.cyc); end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

  task automatic fill_flat(input int v);
    for (int c = 0; c < 3; c++) for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) img[c][y][x] = v;
  endtask

  task automatic fill_impulse();
    fill_flat(50);
    img[0][3][5] = 255;
  endtask

  task automatic fill_ramp();
    for (int c = 0; c < 3; c++) for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) img[c][y][x] = x + 16*y;
  endtask

  task automatic beat(input int p, input int c, input bit l);
    @(negedge clk);
    valid_in = 1'b1; pixel_in = CD'(p); color_in = 3'(c); last_in = l;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      valid_in = 1'($urandom_range(0, 1)); color_in = 3'd3; last_in = 1'b0; pixel_in = CD'($urandom);
    end
  endtask

  task automatic quiet_drain();
    @(negedge clk);
    valid_in = 1'b0; color_in = 3'd3; last_in = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    valid_in = 1'b0; color_in = 3'd3; last_in = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sbq.delete();
  endtask

  // Sends pixels 0..stop_pix; last_in on the final BLUE, or on stop_pix when tlast.
  task automatic send_frame(input int md, input bit gaps, input int stop_pix, input bit tlast,
                            input int chg_pix, input int chg_md);
    int x, y;
    bit l;
    out_cnt = 0; last_cnt = 0;
    mode = 2'(md);
    for (int idx = 0; idx <= stop_pix; idx++) begin
      x = idx % W; y = idx / W;
      if (idx == chg_pix) mode = 2'(chg_md);
      for (int c = 0; c < 3; c++) begin
        l = (c == 2) && ((idx == NPIX-1) || (tlast && idx == stop_pix));
        beat(img[c][y][x], c, l);
        if (x >= 2 && y >= 2)
          sbq.push_back('{c, x-1, y-1, model(c, x-1, y-1, md), (c == 2) && (idx == NPIX-1), cyc+3});
        if (gaps && $urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks += 5;
    if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b want=0", valid_out); end
    if (pixel_out !== '0)   begin errors++; $display("FAIL reset_pixel got=%0d want=0", pixel_out); end
    if (color_out !== 3'd3) begin errors++; $display("FAIL reset_color got=%0d want=3", color_out); end
    if (last_out !== 1'b0)  begin errors++; $display("FAIL reset_last got=%0b want=0", last_out); end
    if (err !== 1'b0)       begin errors++; $display("FAIL reset_err got=%0b want=0", err); end
    rst = 1'b0;
  endtask

  task automatic test_flat(input bit gaps);
    fill_flat(100);
    send_frame(0, gaps, NPIX-1, 0, -1, 0);
    quiet_drain();
    checks += 4;
    if (out_cnt != 120)    begin errors++; $display("FAIL flat_count gaps=%0b got=%0d want=120", gaps, out_cnt); end
    if (last_cnt != 1)     begin errors++; $display("FAIL flat_last_count got=%0d want=1", last_cnt); end
    if (sbq.size() != 0)   begin errors++; $display("FAIL flat_pending got=%0d want=0", sbq.size()); end
    if (err !== 1'b0)      begin errors++; $display("FAIL flat_err got=%0b want=0", err); end
  endtask

  task automatic test_impulse();
    fill_impulse();
    send_frame(0, 0, NPIX-1, 0, -1, 0);
    quiet_drain();
    checks += 5;
    if (got[0][3][5] != 101) begin errors++; $display("FAIL impulse_centre got=%0d want=101", got[0][3][5]); end
    if (got[0][3][4] != 76)  begin errors++; $display("FAIL impulse_left got=%0d want=76", got[0][3][4]); end
    if (got[0][3][6] != 76)  begin errors++; $display("FAIL impulse_right got=%0d want=76", got[0][3][6]); end
    if (got[1][3][5] != 50)  begin errors++; $display("FAIL impulse_green got=%0d want=50", got[1][3][5]); end
    if (out_cnt != 120)      begin errors++; $display("FAIL impulse_count got=%0d want=120", out_cnt); end
    send_frame(2, 0, NPIX-1, 0, -1, 0);
    quiet_drain();
    checks += 2;
    if (got[0][3][5] != 50)  begin errors++; $display("FAIL clamp_centre got=%0d want=50", got[0][3][5]); end
    if (out_cnt != 120)      begin errors++; $display("FAIL clamp_count got=%0d want=120", out_cnt); end
  endtask

  task automatic test_ramp(input bit gaps);
    fill_ramp();
    send_frame(1, gaps, NPIX-1, 0, 30, 0);
    quiet_drain();
    checks += 3;
    if (got[0][2][5] != 37)  begin errors++; $display("FAIL ramp_r52 got=%0d want=37", got[0][2][5]); end
    if (got[2][4][10] != 74) begin errors++; $display("FAIL ramp_b104 got=%0d want=74", got[2][4][10]); end
    if (out_cnt != 120)      begin errors++; $display("FAIL ramp_count gaps=%0b got=%0d want=120", gaps, out_cnt); end
  endtask

  task automatic test_color_err();
    beat(7, 1, 0);
    @(negedge clk);
    valid_in = 1'b0; color_in = 3'd3;
    @(negedge clk);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL color_err got=%0b want=1", err); end
    fill_flat(100);
    send_frame(0, 0, NPIX-1, 0, -1, 0);
    quiet_drain();
    checks += 2;
    if (out_cnt != 120) begin errors++; $display("FAIL after_drop_count got=%0d want=120", out_cnt); end
    if (last_cnt != 1)  begin errors++; $display("FAIL after_drop_last got=%0d want=1", last_cnt); end
  endtask

  task automatic test_trunc();
    do_reset();
    fill_ramp();
    send_frame(1, 0, 30, 1, -1, 0);
    quiet_drain();
    checks += 4;
    if (err !== 1'b1)    begin errors++; $display("FAIL trunc_err got=%0b want=1", err); end
    if (last_cnt != 0)   begin errors++; $display("FAIL trunc_last got=%0d want=0", last_cnt); end
    if (out_cnt != 15)   begin errors++; $display("FAIL trunc_count got=%0d want=15", out_cnt); end
    if (sbq.size() != 0) begin errors++; $display("FAIL trunc_pending got=%0d want=0", sbq.size()); end
    fill_impulse();
    send_frame(0, 0, NPIX-1, 0, -1, 0);
    quiet_drain();
    checks += 3;
    if (out_cnt != 120)      begin errors++; $display("FAIL post_trunc_count got=%0d want=120", out_cnt); end
    if (last_cnt != 1)       begin errors++; $display("FAIL post_trunc_last got=%0d want=1", last_cnt); end
    if (got[0][3][5] != 101) begin errors++; $display("FAIL post_trunc_centre got=%0d want=101", got[0][3][5]); end
  endtask

  task automatic test_reset_mid();
    fill_flat(100);
    send_frame(0, 0, 19, 0, -1, 0);
    #2;
    rst = 1'b1; valid_in = 1'b0; color_in = 3'd3;
    #1;
    checks += 5;
    if (valid_out !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%0b want=0", valid_out); end
    if (pixel_out !== '0)   begin errors++; $display("FAIL midrst_pixel got=%0d want=0", pixel_out); end
    if (color_out !== 3'd3) begin errors++; $display("FAIL midrst_color got=%0d want=3", color_out); end
    if (last_out !== 1'b0)  begin errors++; $display("FAIL midrst_last got=%0b want=0", last_out); end
    if (err !== 1'b0)       begin errors++; $display("FAIL midrst_err got=%0b want=0", err); end
    sbq.delete();
    @(negedge clk);
    rst = 1'b0;
    fill_impulse();
    send_frame(0, 0, NPIX-1, 0, -1, 0);
    quiet_drain();
    checks += 3;
    if (out_cnt != 120)      begin errors++; $display("FAIL midrst_count got=%0d want=120", out_cnt); end
    if (last_cnt != 1)       begin errors++; $display("FAIL midrst_last_count got=%0d want=1", last_cnt); end
    if (got[0][3][5] != 101) begin errors++; $display("FAIL midrst_centre got=%0d want=101", got[0][3][5]); end
  endtask

  initial begin
    test_reset();
    test_flat(0);
    test_impulse();
    test_ramp(0);
    test_flat(1);
    test_ramp(1);
    test_color_err();
    test_trunc();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
